// File: rtl/teng_block_sync.sv
// 10GBASE-R receive block sync: block-lock FSM, gearbox slip control and x^58+x^39+1 descrambler.
// Optional hi-BER monitor is built only when TENG_BLOCK_SYNC_HI_BER_EN is defined.

module teng_block_sync #(
  parameter int unsigned SH_CNT_MAX   = 64,
  parameter int unsigned SH_INVLD_MAX = 16,
  parameter int unsigned SLIP_WAIT    = 32
`ifdef TENG_BLOCK_SYNC_HI_BER_EN
  ,
  parameter int unsigned BER_WINDOW   = 19531
`endif
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] gt_data_i,
  input  logic [1:0]  gt_head_i,
  input  logic        gt_data_vld_i,
  output logic        gearbox_slip_o,
  output logic [63:0] decode_data_o,
  output logic [1:0]  decode_head_o,
  output logic        decode_data_vld_o,
  output logic        block_lock_o,
  output logic        hi_ber_o
);

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned HEAD_W     = 2;
  localparam int unsigned HIST_W     = 58;
  localparam int unsigned TAP_DLY    = 39;
  localparam int unsigned SH_CNT_W   = 7;
  localparam int unsigned SH_INVLD_W = 5;
  localparam int unsigned WAIT_W     = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {
    S_RESET_CNT = 2'd0,
    S_TEST_SH   = 2'd1,
    S_SLIP      = 2'd2,
    S_SLIP_WAIT = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [SH_CNT_W-1:0]     sh_cnt_q, sh_cnt_d, sh_cnt_inc;
  logic [SH_INVLD_W-1:0]   sh_invld_cnt_q, sh_invld_cnt_d, sh_invld_inc;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                    block_lock_q, block_lock_d;
  logic                    slip_q, slip_d;
  logic                    out_vld_q, out_vld_d;
  logic [HIST_W-1:0]       hist_q, hist_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic [HEAD_W-1:0]       out_head_q, out_head_d;
  logic [DATA_W-1:0]       descr;
  logic [DATA_W+HIST_W-1:0] scr_ext;
  logic                    sh_valid;
  logic                    scr_upd;

  assign sh_valid     = (gt_head_i == 2'b01) || (gt_head_i == 2'b10);
  assign sh_cnt_inc   = sh_cnt_q + SH_CNT_W'(1);
  assign sh_invld_inc = sh_invld_cnt_q + SH_INVLD_W'(!sh_valid);

  // Block-lock FSM; slip rules win over the window-end rule on the same word
  always_comb begin
    state_d        = state_q;
    sh_cnt_d       = sh_cnt_q;
    sh_invld_cnt_d = sh_invld_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    block_lock_d   = block_lock_q;
    case (state_q)
      S_RESET_CNT: begin
        sh_cnt_d       = '0;
        sh_invld_cnt_d = '0;
        state_d        = S_TEST_SH;
      end
      S_TEST_SH: begin
        if (gt_data_vld_i) begin
          sh_cnt_d       = sh_cnt_inc;
          sh_invld_cnt_d = sh_invld_inc;
          if (!sh_valid &&
              (!block_lock_q || (sh_invld_inc == SH_INVLD_W'(SH_INVLD_MAX)))) begin
            block_lock_d = 1'b0;
            state_d      = S_SLIP;
          end else if (sh_cnt_inc == SH_CNT_W'(SH_CNT_MAX)) begin
            if (sh_invld_inc == '0) begin
              block_lock_d = 1'b1;
            end
            state_d = S_RESET_CNT;
          end
        end
      end
      S_SLIP: begin
        block_lock_d = 1'b0;
        wait_cnt_d   = WAIT_W'(SLIP_WAIT);
        state_d      = S_SLIP_WAIT;
      end
      S_SLIP_WAIT: begin
        if (gt_data_vld_i) begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
          if (wait_cnt_q <= WAIT_W'(1)) begin
            state_d = S_RESET_CNT;
          end
        end
      end
      default: state_d = S_RESET_CNT;
    endcase
  end

  // Self-synchronous descrambler over {current word, 58-bit scrambled history}
  assign scr_ext = {gt_data_i, hist_q};

  always_comb begin
    descr = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      descr[i] = scr_ext[i + HIST_W] ^ scr_ext[i + HIST_W - TAP_DLY] ^ scr_ext[i];
    end
  end

  // History and output stage; the slip-triggering word is never presented
  always_comb begin
    slip_d     = (state_d == S_SLIP);
    scr_upd    = gt_data_vld_i && ((state_q == S_RESET_CNT) || (state_q == S_TEST_SH));
    hist_d     = scr_upd ? gt_data_i[DATA_W-1:DATA_W-HIST_W] : hist_q;
    out_vld_d  = scr_upd && block_lock_q && (state_d != S_SLIP);
    out_data_d = out_vld_d ? descr : out_data_q;
    out_head_d = out_vld_d ? gt_head_i : out_head_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= S_RESET_CNT;
      sh_cnt_q       <= '0;
      sh_invld_cnt_q <= '0;
      wait_cnt_q     <= '0;
      block_lock_q   <= 1'b0;
      slip_q         <= 1'b0;
      out_vld_q      <= 1'b0;
      hist_q         <= '0;
      out_data_q     <= '0;
      out_head_q     <= '0;
    end else begin
      state_q        <= state_d;
      sh_cnt_q       <= sh_cnt_d;
      sh_invld_cnt_q <= sh_invld_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      block_lock_q   <= block_lock_d;
      slip_q         <= slip_d;
      out_vld_q      <= out_vld_d;
      hist_q         <= hist_d;
      out_data_q     <= out_data_d;
      out_head_q     <= out_head_d;
    end
  end

  assign gearbox_slip_o    = slip_q;
  assign block_lock_o      = block_lock_q;
  assign decode_data_vld_o = out_vld_q;
  assign decode_data_o     = out_data_q;
  assign decode_head_o     = out_head_q;

`ifdef TENG_BLOCK_SYNC_HI_BER_EN
  localparam int unsigned BER_WIN_W = $clog2(BER_WINDOW + 1);
  localparam int unsigned BER_CNT_W = 5;
  localparam int unsigned BER_TRIP  = 16;

  logic [BER_WIN_W-1:0] ber_win_q, ber_win_d;
  logic [BER_CNT_W-1:0] ber_cnt_q, ber_cnt_d, ber_cnt_inc;
  logic                 hi_ber_q, hi_ber_d;

  // Windowed saturating count of bad headers, paused while the gearbox realigns
  always_comb begin
    ber_win_d   = ber_win_q;
    ber_cnt_d   = ber_cnt_q;
    hi_ber_d    = hi_ber_q;
    ber_cnt_inc = (sh_valid || (ber_cnt_q == '1)) ? ber_cnt_q : ber_cnt_q + BER_CNT_W'(1);
    if (gt_data_vld_i && (state_q != S_SLIP_WAIT)) begin
      if (ber_win_q == BER_WIN_W'(BER_WINDOW - 1)) begin
        hi_ber_d  = (ber_cnt_inc >= BER_CNT_W'(BER_TRIP));
        ber_cnt_d = '0;
        ber_win_d = '0;
      end else begin
        ber_win_d = ber_win_q + BER_WIN_W'(1);
        ber_cnt_d = ber_cnt_inc;
        if (ber_cnt_inc >= BER_CNT_W'(BER_TRIP)) begin
          hi_ber_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ber_win_q <= '0;
      ber_cnt_q <= '0;
      hi_ber_q  <= 1'b0;
    end else begin
      ber_win_q <= ber_win_d;
      ber_cnt_q <= ber_cnt_d;
      hi_ber_q  <= hi_ber_d;
    end
  end

  assign hi_ber_o = hi_ber_q;
`else
  assign hi_ber_o = 1'b0;
`endif

endmodule

// File: tb/tb_teng_block_sync.sv
// Randomized self-checking bench for teng_block_sync: scrambles known payloads and compares
// every output each cycle against a word-level reference of the lock/slip/descramble rules.

module tb_teng_block_sync;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [63:0] gt_data_i = '0;
  logic [1:0]  gt_head_i = '0;
  logic        gt_data_vld_i = 1'b0;
  logic        gearbox_slip_o;
  logic [63:0] decode_data_o;
  logic [1:0]  decode_head_o;
  logic        decode_data_vld_o;
  logic        block_lock_o;
  logic        hi_ber_o;

  always #5 clk_i = ~clk_i;

`ifdef TENG_BLOCK_SYNC_HI_BER_EN
  teng_block_sync #(.BER_WINDOW(100)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .gt_data_i(gt_data_i), .gt_head_i(gt_head_i),
    .gt_data_vld_i(gt_data_vld_i), .gearbox_slip_o(gearbox_slip_o),
    .decode_data_o(decode_data_o), .decode_head_o(decode_head_o),
    .decode_data_vld_o(decode_data_vld_o), .block_lock_o(block_lock_o), .hi_ber_o(hi_ber_o)
  );
`else
  teng_block_sync dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .gt_data_i(gt_data_i), .gt_head_i(gt_head_i),
    .gt_data_vld_i(gt_data_vld_i), .gearbox_slip_o(gearbox_slip_o),
    .decode_data_o(decode_data_o), .decode_head_o(decode_head_o),
    .decode_data_vld_o(decode_data_vld_o), .block_lock_o(block_lock_o), .hi_ber_o(hi_ber_o)
  );
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: what the link-level rules say each word should do
  localparam int PH_CLEAR = 0;
  localparam int PH_TEST  = 1;
  localparam int PH_SLIP  = 2;
  localparam int PH_WAIT  = 3;

  int          m_phase;
  int          m_tested;
  int          m_bad;
  int          m_ignore;
  bit          m_lock;
  bit          m_slip;
  bit          m_ovld;
  bit          m_hi;
  logic [63:0] m_odata;
  logic [1:0]  m_ohead;
  int          b_words;
  int          b_bad;
  logic [57:0] scr_st = '1;

  task automatic model_reset();
    m_phase = PH_CLEAR; m_tested = 0; m_bad = 0; m_ignore = 0;
    m_lock = 0; m_slip = 0; m_ovld = 0; m_hi = 0;
    m_odata = '0; m_ohead = '0; b_words = 0; b_bad = 0;
  endtask

  task automatic model_step(input bit vld, input logic [1:0] head, input logic [63:0] p);
    bit good;
    bit show;
    good = (head == 2'b01) || (head == 2'b10);
    show = 0;
    m_slip = 0;
`ifdef TENG_BLOCK_SYNC_HI_BER_EN
    if (vld && m_phase != PH_WAIT) begin
      b_words++;
      if (!good && b_bad < 31) b_bad++;
      if (b_words == 100) begin
        m_hi = (b_bad >= 16);
        b_bad = 0;
        b_words = 0;
      end else if (b_bad >= 16) begin
        m_hi = 1;
      end
    end
`endif
    if (m_phase == PH_CLEAR) begin
      m_tested = 0; m_bad = 0;
      show = vld && m_lock;
      m_phase = PH_TEST;
    end else if (m_phase == PH_TEST) begin
      if (vld) begin
        m_tested++;
        if (!good) m_bad++;
        if (!good && (!m_lock || m_bad == 16)) begin
          m_lock = 0;
          m_slip = 1;
          m_phase = PH_SLIP;
        end else begin
          show = m_lock;
          if (m_tested == 64) begin
            if (m_bad == 0) m_lock = 1;
            m_phase = PH_CLEAR;
          end
        end
      end
    end else if (m_phase == PH_SLIP) begin
      m_lock = 0;
      m_ignore = 32;
      m_phase = PH_WAIT;
    end else begin
      if (vld) begin
        m_ignore--;
        if (m_ignore == 0) m_phase = PH_CLEAR;
      end
    end
    m_ovld = show;
    if (show) begin
      m_odata = p;
      m_ohead = head;
    end
  endtask

  // Bit-serial reference scrambler, bit 0 first
  task automatic scramble(input logic [63:0] p, output logic [63:0] s);
    logic b;
    for (int i = 0; i < 64; i++) begin
      b = p[i] ^ scr_st[38] ^ scr_st[57];
      s[i] = b;
      scr_st = {scr_st[56:0], b};
    end
  endtask

  task automatic compare_all();
    check("block_lock", 64'(block_lock_o), 64'(m_lock));
    check("gearbox_slip", 64'(gearbox_slip_o), 64'(m_slip));
    check("decode_vld", 64'(decode_data_vld_o), 64'(m_ovld));
    check("decode_head", 64'(decode_head_o), 64'(m_ohead));
    check("decode_data", decode_data_o, m_odata);
    check("hi_ber", 64'(hi_ber_o), 64'(m_hi));
  endtask

  task automatic cycle(input bit vld, input logic [1:0] head, input logic [63:0] p);
    logic [63:0] s;
    if (vld) scramble(p, s);
    else s = {$urandom, $urandom};
    gt_data_vld_i = vld;
    gt_head_i     = head;
    gt_data_i     = s;
    model_step(vld, head, p);
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  function automatic logic [1:0] good_head();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_head();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [63:0] payload();
    return ($urandom_range(0, 3) == 0) ? 64'h0000_0000_0000_001E : {$urandom, $urandom};
  endfunction

  // Feed clean headers until lock; returns the number of valid words fed
  task automatic feed_until_lock(input int limit, input int vld_pct, output int nvld);
    bit v;
    nvld = 0;
    for (int c = 0; c < limit && !block_lock_o; c++) begin
      v = ($urandom_range(0, 99) < vld_pct);
      if (v) nvld++;
      cycle(v, good_head(), payload());
    end
    check("lock_reached", 64'(block_lock_o), 64'd1);
  endtask

  initial begin
    int nvld;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    compare_all();
    rst_n_i = 1'b1;

    // Misaligned start: first tested word has a bad header
    cycle(1, good_head(), payload());
    cycle(1, 2'b11, payload());
    check("slip_on_bad_head", 64'(gearbox_slip_o), 64'd1);
    repeat (33) cycle(1, good_head(), payload());
    feed_until_lock(200, 100, nvld);
    check("relock_words_after_slip", 64'(nvld), 64'd65);

    // Lock loss: 15 bad in one window holds lock, 16 drops it
    cycle(1, good_head(), payload());
    repeat (15) cycle(1, bad_head(), payload());
    check("lock_held_15_bad", 64'(block_lock_o), 64'd1);
    repeat (49) cycle(1, good_head(), payload());
    cycle(1, good_head(), payload());
    repeat (15) cycle(1, bad_head(), payload());
    check("lock_held_again", 64'(block_lock_o), 64'd1);
    cycle(1, bad_head(), payload());
    check("lock_drop_16th_bad", 64'(block_lock_o), 64'd0);
    check("slip_after_16th_bad", 64'(gearbox_slip_o), 64'd1);
    check("vld_stops_on_drop", 64'(decode_data_vld_o), 64'd0);

    // Reset while the slip pulse is high
    rst_n_i = 1'b0;
    #1;
    model_reset();
    check("rst_slip", 64'(gearbox_slip_o), 64'd0);
    check("rst_lock", 64'(block_lock_o), 64'd0);
    check("rst_vld", 64'(decode_data_vld_o), 64'd0);
    check("rst_data", decode_data_o, 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    compare_all();
    rst_n_i = 1'b1;

    // Valid gaps: lock still needs exactly 64 tested words
    cycle(0, good_head(), payload());
    feed_until_lock(1000, 50, nvld);
    check("gap_lock_words", 64'(nvld), 64'd64);
    repeat (100) cycle($urandom_range(0, 1) == 1, good_head(), payload());

    // Random traffic with sparse header errors and bursts
    for (int c = 0; c < 3000; c++) begin
      bit v;
      logic [1:0] h;
      v = ($urandom_range(0, 99) < 75);
      h = ($urandom_range(0, 199) == 0) ? bad_head() : good_head();
      if (c >= 2000 && c < 2040 && $urandom_range(0, 1) == 0) h = bad_head();
      cycle(v, h, payload());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
